if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction fetch stage plus IF/ID pipeline register; sits directly upstream of the RV32I decoder.
//  Owns the PC, issues word fetches to instruction memory over a req/gnt + rvalid handshake,
//  and buffers one returned instruction so a downstream stall never loses a fetch.
//  Presents inst/PC to decode and splits opcode/funct3/funct7 for the decoder inputs.
//  A branch/jump redirect from EXE flushes the stage.
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h0000_0000 first fetch address after reset
//  NOP_INST  32'h0000_0013 bubble instruction (addi x0,x0,0)
// PORTS
//  clk_i          in   1     clock, all state on rising edge
//  rst_i          in   1     synchronous, active-high reset
//  im_req_o       out  1     fetch request valid
//  im_addr_o      out  XLEN  fetch byte address, [1:0] always 2'b00
//  im_gnt_i       in   1     request accepted this cycle (im_req_o & im_gnt_i)
//  im_rvalid_i    in   1     read data valid, in order, >=1 cycle after gnt
//  im_rdata_i     in   32    instruction word
//  stall_i        in   1     decode hazard: hold IF/ID contents
//  redirect_en_i  in   1     taken branch/jump: flush and refetch
//  redirect_pc_i  in   XLEN  redirect target ([1:0] ignored, forced 0)
//  id_valid_o     out  1     IF/ID holds a real instruction
//  id_inst_o      out  32    IF/ID instruction (NOP_INST when invalid)
//  id_pc_o        out  XLEN  PC of id_inst_o
//  id_pc4_o       out  XLEN  id_pc_o + 4 (link value for jal/jalr)
//  opcode_o       out  7     id_inst_o[6:0]
//  funct3_o       out  3     id_inst_o[14:12]
//  funct7_o       out  7     id_inst_o[31:25]
// BEHAVIOUR
//  Reset: state=REQ, pc_q=RESET_PC, buf empty, id_valid_o=0, id_inst_o=NOP_INST, id_pc_o=0;
//   im_req_o=0 during reset cycle, =1 with im_addr_o=RESET_PC the first cycle after rst_i low.
//  FSM REQ/WAIT/HOLD/DROP; max one outstanding fetch; rvalid outside WAIT/DROP is ignored.
//   REQ : im_req_o=1, im_addr_o=pc_q. On gnt: req_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32 wrap), ->WAIT.
//   WAIT: im_req_o=0. On rvalid: if IF/ID free (!id_valid_o | !stall_i) load IF/ID, ->REQ;
//         else write buf (inst, req_pc_q), ->HOLD.
//   HOLD: im_req_o=0; when !stall_i, buf moves into IF/ID, buf empties, ->REQ.
//   DROP: im_req_o=0; next rvalid discarded, ->REQ.
//  IF/ID update when !stall_i: load buf if full, else arriving WAIT response, else bubble
//   (id_valid_o=0, id_inst_o=NOP_INST, id_pc_o holds). When stall_i: IF/ID holds.
//  Latency: gnt at cycle t, rvalid at t+k -> id_valid_o at t+k+1. Throughput 1 inst / 2 cycles
//   with k=1 (new request the cycle after rvalid).
//  Redirect (priority over stall, below reset): pc_q<=redirect_pc_i & ~3; IF/ID -> bubble; buf cleared.
//   From WAIT without rvalid, or REQ with gnt same cycle: ->DROP. WAIT with rvalid same cycle:
//   data discarded, ->REQ. From REQ (no gnt)/HOLD/DROP-with-rvalid: ->REQ. DROP without rvalid stays DROP.
//  rst_i mid-fetch: everything returns to reset values; instruction memory shares rst_i.
//  opcode_o/funct3_o/funct7_o and id_pc4_o are combinational from IF/ID register.
// TESTING
//  1 Reset, mem k=1 always-gnt, words 0x00500093,0x00A00113 -> id_inst 0x00500093 @pc 0,
//    0x00A00113 @pc 4 two cycles later; opcode_o=7'h13; id_pc4_o=4 then 8.
//  2 stall_i held 5 cycles while response returns -> buf captures, im_req_o=0 in HOLD, no word lost,
//    PC sequence 0,4,8 in order once stall_i drops.
//  3 redirect_en_i to 0x0000_0103 while WAIT -> late rvalid discarded, next im_addr_o=0x100,
//    id_valid_o=0 next cycle.
//  4 redirect same cycle as rvalid and stall_i=1 -> data dropped, IF/ID bubble, fetch at target.
//  5 redirect_pc_i=32'hFFFF_FFFC -> fetch 0xFFFF_FFFC then 0x0000_0000 (wrap).
//  6 rst_i asserted in WAIT, random gnt latency 1..4 -> outputs at reset values, refetch RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory fetch port (req/gnt + rvalid) between IF stage and imem
interface if_stage_if #(
  parameter int XLEN = 32
);
  logic            im_req_o;
  logic [XLEN-1:0] im_addr_o;
  logic            im_gnt_i;
  logic            im_rvalid_i;
  logic [31:0]     im_rdata_i;

  modport master (
    output im_req_o,
    output im_addr_o,
    input  im_gnt_i,
    input  im_rvalid_i,
    input  im_rdata_i
  );

  modport slave (
    input  im_req_o,
    input  im_addr_o,
    output im_gnt_i,
    output im_rvalid_i,
    output im_rdata_i
  );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I fetch stage with one-entry response buffer and IF/ID pipeline register
module if_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  if_stage_if.master      im,
  input  logic            stall_i,
  input  logic            redirect_en_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  output logic [31:0]     id_inst_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc4_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  localparam logic [XLEN-1:0] PC_START = {RESET_PC[XLEN-1:2], 2'b00};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] w_req_pc_nxt;

  logic            r_buf_valid;
  logic            w_buf_valid_nxt;
  logic [31:0]     r_buf_inst;
  logic [31:0]     w_buf_inst_nxt;
  logic [XLEN-1:0] r_buf_pc;
  logic [XLEN-1:0] w_buf_pc_nxt;

  logic            r_id_valid;
  logic            w_id_valid_nxt;
  logic [31:0]     r_id_inst;
  logic [31:0]     w_id_inst_nxt;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] w_id_pc_nxt;

  logic            w_fire;
  logic            w_rsp;
  logic            w_id_free;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_fire        = (r_state == S_REQ) && im.im_gnt_i;
  assign w_rsp         = im.im_rvalid_i;
  assign w_id_free     = !r_id_valid || !stall_i;
  assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

  // The request is masked during the reset cycle so memory never sees a stale address.
  assign im.im_req_o  = (r_state == S_REQ) && !rst_i;
  assign im.im_addr_o = r_pc;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_pc_nxt    = r_req_pc;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_inst_nxt  = r_buf_inst;
    w_buf_pc_nxt    = r_buf_pc;
    w_id_valid_nxt  = r_id_valid;
    w_id_inst_nxt   = r_id_inst;
    w_id_pc_nxt     = r_id_pc;

    // Decode advances this cycle: unless something loads below, a bubble follows.
    if (!stall_i) begin
      w_id_valid_nxt = 1'b0;
      w_id_inst_nxt  = NOP_INST;
    end

    unique case (r_state)
      S_REQ: begin
        if (w_fire) begin
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + XLEN'(4);
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_rsp) begin
          if (w_id_free) begin
            w_id_valid_nxt = 1'b1;
            w_id_inst_nxt  = im.im_rdata_i;
            w_id_pc_nxt    = r_req_pc;
            w_state_nxt    = S_REQ;
          end else begin
            w_buf_valid_nxt = 1'b1;
            w_buf_inst_nxt  = im.im_rdata_i;
            w_buf_pc_nxt    = r_req_pc;
            w_state_nxt     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          w_id_valid_nxt  = r_buf_valid;
          w_id_inst_nxt   = r_buf_valid ? r_buf_inst : NOP_INST;
          w_id_pc_nxt     = r_buf_valid ? r_buf_pc : r_id_pc;
          w_buf_valid_nxt = 1'b0;
          w_state_nxt     = S_REQ;
        end
      end
      S_DROP: begin
        if (w_rsp) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    // A redirect kills everything younger than EXE; a fetch still in flight must drain in DROP.
    if (redirect_en_i) begin
      w_pc_nxt        = w_redirect_pc;
      w_id_valid_nxt  = 1'b0;
      w_id_inst_nxt   = NOP_INST;
      w_id_pc_nxt     = r_id_pc;
      w_buf_valid_nxt = 1'b0;
      unique case (r_state)
        S_REQ:   w_state_nxt = w_fire ? S_DROP : S_REQ;
        S_WAIT:  w_state_nxt = w_rsp ? S_REQ : S_DROP;
        S_HOLD:  w_state_nxt = S_REQ;
        S_DROP:  w_state_nxt = w_rsp ? S_REQ : S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_REQ;
      r_pc        <= PC_START;
      r_req_pc    <= PC_START;
      r_buf_valid <= 1'b0;
      r_buf_inst  <= NOP_INST;
      r_buf_pc    <= '0;
      r_id_valid  <= 1'b0;
      r_id_inst   <= NOP_INST;
      r_id_pc     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_inst  <= w_buf_inst_nxt;
      r_buf_pc    <= w_buf_pc_nxt;
      r_id_valid  <= w_id_valid_nxt;
      r_id_inst   <= w_id_inst_nxt;
      r_id_pc     <= w_id_pc_nxt;
    end
  end

  assign id_valid_o = r_id_valid;
  assign id_inst_o  = r_id_inst;
  assign id_pc_o    = r_id_pc;
  assign id_pc4_o   = r_id_pc + XLEN'(4);
  assign opcode_o   = r_id_inst[6:0];
  assign funct3_o   = r_id_inst[14:12];
  assign funct7_o   = r_id_inst[31:25];

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized bench for if_stage against a fetch/consume stream model
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_en_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;
    logic [6:0]  opcode_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;

    if_stage_if #(.XLEN(32)) im ();

    if_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .im            (im),
        .stall_i       (stall_i),
        .redirect_en_i (redirect_en_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_inst_o     (id_inst_o),
        .id_pc_o       (id_pc_o),
        .id_pc4_o      (id_pc4_o),
        .opcode_o      (opcode_o),
        .funct3_o      (funct3_o),
        .funct7_o      (funct7_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        ctl_rst   = 1'b1;
    logic        ctl_stall = 1'b0;
    logic        ctl_redir = 1'b0;
    logic [31:0] ctl_tgt   = '0;
    int          gnt_mode  = 1;
    int          lat_fixed = 1;

    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;

    logic [31:0] exp_fetch = '0;
    logic [31:0] exp_cons  = '0;
    logic        outst     = 1'b0;
    int          n_cons    = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_1013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        logic [31:0] w;
        @(negedge clk);
        rst_i         = ctl_rst;
        stall_i       = ctl_stall;
        redirect_en_i = ctl_redir;
        redirect_pc_i = ctl_tgt;
        im.im_rvalid_i = 1'b0;
        im.im_rdata_i  = $urandom;
        if (ctl_rst) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                im.im_rvalid_i = 1'b1;
                im.im_rdata_i  = mem_word(mem_addr);
                mem_busy = 1'b0;
            end
        end
        case (gnt_mode)
            0:       im.im_gnt_i = 1'b0;
            1:       im.im_gnt_i = 1'b1;
            default: im.im_gnt_i = ($urandom_range(0, 9) < 7);
        endcase
        #1;
        if (ctl_rst) begin
            check("req_in_reset", 32'(im.im_req_o), 32'h0);
            exp_fetch = 32'h0;
            exp_cons  = 32'h0;
            outst     = 1'b0;
        end else begin
            if (outst) check("one_outstanding", 32'(im.im_req_o), 32'h0);
            if (im.im_req_o) check("addr_align", 32'(im.im_addr_o[1:0]), 32'h0);
            if (im.im_rvalid_i) outst = 1'b0;
            if (im.im_req_o && im.im_gnt_i) begin
                check("fetch_addr", im.im_addr_o, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                outst     = 1'b1;
                mem_busy  = 1'b1;
                mem_addr  = im.im_addr_o;
                mem_cnt   = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
            end
            if (!id_valid_o) begin
                check("bubble_nop", id_inst_o, NOP);
            end else if (!ctl_stall && !ctl_redir) begin
                w = mem_word(exp_cons);
                check("cons_pc", id_pc_o, exp_cons);
                check("cons_inst", id_inst_o, w);
                check("cons_pc4", id_pc4_o, exp_cons + 32'd4);
                check("cons_opcode", 32'(opcode_o), 32'(w[6:0]));
                check("cons_funct3", 32'(funct3_o), 32'(w[14:12]));
                check("cons_funct7", 32'(funct7_o), 32'(w[31:25]));
                exp_cons = exp_cons + 32'd4;
                n_cons++;
            end
            if (ctl_redir) begin
                exp_fetch = ctl_tgt & ~32'h3;
                exp_cons  = ctl_tgt & ~32'h3;
            end
        end
    endtask

    task automatic do_reset();
        ctl_rst   = 1'b1;
        ctl_stall = 1'b0;
        ctl_redir = 1'b0;
        repeat (2) cyc();
        ctl_rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: basic in-order fetch, k=1, always granted
        gnt_mode = 1; lat_fixed = 1;
        do_reset();
        cyc();
        check("t1_req", 32'(im.im_req_o), 32'h1);
        check("t1_addr", im.im_addr_o, 32'h0);
        check("t1_rst_valid", 32'(id_valid_o), 32'h0);
        check("t1_rst_inst", id_inst_o, NOP);
        check("t1_rst_pc", id_pc_o, 32'h0);
        cyc();
        cyc();
        check("t1_v0", 32'(id_valid_o), 32'h1);
        check("t1_inst0", id_inst_o, 32'h0050_0093);
        check("t1_pc0", id_pc_o, 32'h0);
        check("t1_op0", 32'(opcode_o), 32'h13);
        check("t1_pc4_0", id_pc4_o, 32'h4);
        cyc();
        check("t1_gap", 32'(id_valid_o), 32'h0);
        cyc();
        check("t1_inst1", id_inst_o, 32'h00A0_0113);
        check("t1_pc1", id_pc_o, 32'h4);
        check("t1_pc4_1", id_pc4_o, 32'h8);

        // 2: five-cycle stall while a response returns
        do_reset();
        cyc(); cyc();
        ctl_stall = 1'b1;
        cyc();
        check("t2_hold_pc0", id_pc_o, 32'h0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t2_req_hold", 32'(im.im_req_o), 32'h0);
        end
        ctl_stall = 1'b0;
        cyc();
        check("t2_pc0", id_pc_o, 32'h0);
        cyc();
        check("t2_pc4", id_pc_o, 32'h4);
        check("t2_v4", 32'(id_valid_o), 32'h1);
        cyc();
        cyc();
        check("t2_pc8", id_pc_o, 32'h8);
        check("t2_v8", 32'(id_valid_o), 32'h1);

        // 3: redirect during WAIT, late response discarded
        lat_fixed = 3;
        do_reset();
        cyc();
        ctl_redir = 1'b1; ctl_tgt = 32'h0000_0103;
        cyc();
        ctl_redir = 1'b0;
        cyc();
        check("t3_bubble", 32'(id_valid_o), 32'h0);
        check("t3_drop_req", 32'(im.im_req_o), 32'h0);
        cyc();
        cyc();
        check("t3_req", 32'(im.im_req_o), 32'h1);
        check("t3_addr", im.im_addr_o, 32'h0000_0100);
        check("t3_still_bubble", 32'(id_valid_o), 32'h0);

        // 4: redirect with rvalid and stall in the same cycle
        lat_fixed = 1;
        do_reset();
        cyc(); cyc();
        ctl_stall = 1'b1;
        cyc();
        ctl_redir = 1'b1; ctl_tgt = 32'h0000_0200;
        cyc();
        ctl_redir = 1'b0; ctl_stall = 1'b0;
        cyc();
        check("t4_bubble", 32'(id_valid_o), 32'h0);
        check("t4_nop", id_inst_o, NOP);
        check("t4_addr", im.im_addr_o, 32'h0000_0200);
        cyc(); cyc();
        check("t4_pc", id_pc_o, 32'h0000_0200);

        // 5: address wrap at the top of memory
        do_reset();
        gnt_mode = 0;
        ctl_redir = 1'b1; ctl_tgt = 32'hFFFF_FFFE;
        cyc();
        ctl_redir = 1'b0; gnt_mode = 1;
        cyc();
        check("t5_addr_top", im.im_addr_o, 32'hFFFF_FFFC);
        cyc(); cyc();
        check("t5_pc", id_pc_o, 32'hFFFF_FFFC);
        check("t5_pc4_wrap", id_pc4_o, 32'h0);
        check("t5_addr_wrap", im.im_addr_o, 32'h0);

        // 6: reset while a fetch is outstanding, random latency
        lat_fixed = 0; gnt_mode = 2;
        for (int it = 0; it < 20; it++) begin
            int w;
            do_reset();
            repeat ($urandom_range(0, 20)) cyc();
            w = 0;
            while (!outst && w < 50) begin
                cyc();
                w++;
            end
            check("t6_reach_wait", 32'(outst), 32'h1);
            ctl_rst = 1'b1;
            cyc();
            ctl_rst = 1'b0;
            cyc();
            check("t6_valid", 32'(id_valid_o), 32'h0);
            check("t6_inst", id_inst_o, NOP);
            check("t6_pc", id_pc_o, 32'h0);
            check("t6_req", 32'(im.im_req_o), 32'h1);
            check("t6_addr", im.im_addr_o, 32'h0);
        end

        // random traffic against the stream model
        n_cons = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            ctl_stall = ($urandom_range(0, 9) < 3);
            ctl_redir = ($urandom_range(0, 99) < 4);
            ctl_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : $urandom;
            ctl_rst   = ($urandom_range(0, 999) < 3);
            cyc();
        end
        ctl_rst = 1'b0; ctl_stall = 1'b0; ctl_redir = 1'b0;
        check("rand_progress", 32'(n_cons >= 200), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
